usb_fs_rx_frontend: RTL

Full-speed (12 Mb/s) USB receive front-end clocked by the 48 MHz PLL domain. It samples raw D+/D- at 4× oversampling and recovers bit timing with a digital phase tracker. It NRZI-decodes, removes stuff bits, and detects SYNC, EOP and bus reset. Its output is a strobed decoded bit stream for the packet/byte layer downstream.

---
 rtl/usb_fs_pkg.sv | 37 +++
 rtl/usb_fs_line_sync.sv | 43 ++++
 rtl/usb_fs_rx_frontend.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fs_pkg.sv
// Shared types and constants for the full-speed USB receive front-end.
package usb_fs_pkg;

  // Encodings equal the synchronized {dp, dm} pair.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b10,
    LS_K   = 2'b01,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ABORT
  } rx_state_t;

  localparam int BIT_CYCLES     = 4;
  localparam int SAMPLE_PHASE   = 2;
  localparam int STUFF_LIMIT    = 6;
  localparam int SYNC_MIN_ZEROS = 3;

  localparam int PHASE_W = $clog2(BIT_CYCLES);
  localparam int ONES_W  = $clog2(STUFF_LIMIT + 1);
  localparam int ZEROS_W = $clog2(SYNC_MIN_ZEROS + 1);

  function automatic line_state_t to_line_state(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction

  function automatic logic is_jk(input line_state_t ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_fs_line_sync.sv
// dp/dm metastability synchronizer, registered line state and J<->K edge flag.
module usb_fs_line_sync
  import usb_fs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_48m,
  input  logic        safe_rst_n,
  input  logic        i_dp,
  input  logic        i_dm,
  output line_state_t o_line_state,
  output logic        o_edge
);

  logic [SYNC_STAGES-1:0] r_dp_sync;
  logic [SYNC_STAGES-1:0] r_dm_sync;
  line_state_t            r_line_state;
  logic                   r_edge;
  line_state_t            w_line;
  logic                   w_jk_change;

  assign w_line      = to_line_state(r_dp_sync[SYNC_STAGES-1], r_dm_sync[SYNC_STAGES-1]);
  // Only J<->K transitions carry timing; SE0/SE1 boundaries do not resync the phase.
  assign w_jk_change = (w_line != r_line_state) && is_jk(w_line) && is_jk(r_line_state);

  always_ff @(posedge clk_48m or negedge safe_rst_n) begin
    if (!safe_rst_n) begin
      r_dp_sync    <= '1;
      r_dm_sync    <= '0;
      r_line_state <= LS_J;
      r_edge       <= 1'b0;
    end else begin
      r_dp_sync    <= {r_dp_sync[SYNC_STAGES-2:0], i_dp};
      r_dm_sync    <= {r_dm_sync[SYNC_STAGES-2:0], i_dm};
      r_line_state <= w_line;
      r_edge       <= w_jk_change;
    end
  end

  assign o_line_state = r_line_state;
  assign o_edge       = r_edge;

endmodule

// File: rtl/usb_fs_rx_frontend.sv
// Full-speed USB RX front-end: phase tracking, NRZI decode, destuffing, SYNC/EOP/bus reset.
// Optional statistics counters are built when USB_RX_STATS_EN is defined.
module usb_fs_rx_frontend
  import usb_fs_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 120
) (
  input  logic        clk_48m,
  input  logic        safe_rst_n,
  input  logic        i_dp_in,
  input  logic        i_dm_in,
  input  logic        i_rx_en,
  output logic        o_rx_active,
  output logic        o_bit_valid,
  output logic        o_bit_data,
  output logic        o_eop,
  output logic        o_stuff_err,
  output logic        o_bus_reset,
  output logic [15:0] o_pkt_count,
  output logic [15:0] o_err_count
);

  localparam int RST_CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RST_CNT_W-1:0] RST_CNT_MAX = RST_CNT_W'(RESET_CYCLES);

  line_state_t          w_line_state;
  logic                 w_edge;
  logic [PHASE_W-1:0]   r_phase;
  logic [PHASE_W-1:0]   w_phase;
  logic                 w_sample_en;
  logic                 w_is_j;
  logic                 w_is_k;
  logic                 w_is_se0;
  logic                 w_nrzi_bit;

  logic [RST_CNT_W-1:0] r_se0_cnt;
  logic [RST_CNT_W-1:0] w_se0_cnt_next;
  logic                 r_bus_reset;
  logic                 w_bus_reset_next;

  rx_state_t            r_state, w_state_next;
  line_state_t          r_prev_sample, w_prev_next;
  logic [ZEROS_W-1:0]   r_zeros, w_zeros_next;
  logic [ONES_W-1:0]    r_ones, w_ones_next;
  logic                 r_rx_active, w_rx_active_next;
  logic                 r_bit_valid, w_bit_valid_next;
  logic                 r_bit_data, w_bit_data_next;
  logic                 r_eop, w_eop_next;
  logic                 r_stuff_err, w_stuff_err_next;

  usb_fs_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_48m      (clk_48m),
    .safe_rst_n   (safe_rst_n),
    .i_dp         (i_dp_in),
    .i_dm         (i_dm_in),
    .o_line_state (w_line_state),
    .o_edge       (w_edge)
  );

  // Phase is 0 in the very cycle an edge is seen, so the sample lands two cycles later.
  assign w_phase     = w_edge ? '0 : r_phase + 1'b1;
  assign w_sample_en = (w_phase == PHASE_W'(SAMPLE_PHASE));
  assign w_is_j      = (w_line_state == LS_J);
  assign w_is_k      = (w_line_state == LS_K);
  assign w_is_se0    = (w_line_state == LS_SE0) || (w_line_state == LS_SE1);
  assign w_nrzi_bit  = (w_line_state == r_prev_sample);

  always_comb begin
    w_se0_cnt_next = '0;
    if (i_rx_en && (w_line_state == LS_SE0)) begin
      w_se0_cnt_next = (r_se0_cnt == RST_CNT_MAX) ? r_se0_cnt : r_se0_cnt + 1'b1;
    end
    w_bus_reset_next = (w_se0_cnt_next == RST_CNT_MAX);
  end

  always_comb begin
    w_state_next     = r_state;
    w_prev_next      = r_prev_sample;
    w_zeros_next     = r_zeros;
    w_ones_next      = r_ones;
    w_rx_active_next = r_rx_active;
    w_bit_valid_next = 1'b0;
    w_bit_data_next  = 1'b0;
    w_eop_next       = 1'b0;
    w_stuff_err_next = 1'b0;

    if (!i_rx_en || r_bus_reset) begin
      w_state_next     = IDLE;
      w_prev_next      = LS_J;
      w_zeros_next     = '0;
      w_ones_next      = '0;
      w_rx_active_next = 1'b0;
    end else if (w_sample_en) begin
      if (is_jk(w_line_state)) begin
        w_prev_next = w_line_state;
      end
      case (r_state)
        IDLE: begin
          if (w_is_k) begin
            w_state_next = SYNC;
            w_zeros_next = ZEROS_W'(1);
          end
        end
        SYNC: begin
          if (w_is_se0) begin
            w_state_next = IDLE;
            w_prev_next  = LS_J;
          end else if (!w_nrzi_bit) begin
            if (r_zeros != ZEROS_W'(SYNC_MIN_ZEROS)) begin
              w_zeros_next = r_zeros + 1'b1;
            end
          end else if (r_zeros >= ZEROS_W'(SYNC_MIN_ZEROS)) begin
            // Stuffing run starts fresh with the first payload bit.
            w_state_next     = DATA;
            w_rx_active_next = 1'b1;
            w_ones_next      = '0;
          end else begin
            w_state_next = IDLE;
            w_prev_next  = LS_J;
          end
        end
        DATA: begin
          if (w_is_se0) begin
            w_state_next = EOP;
          end else if (r_ones == ONES_W'(STUFF_LIMIT)) begin
            if (w_nrzi_bit) begin
              w_stuff_err_next = 1'b1;
              w_rx_active_next = 1'b0;
              w_state_next     = ABORT;
            end else begin
              w_ones_next = '0;
            end
          end else begin
            w_bit_valid_next = 1'b1;
            w_bit_data_next  = w_nrzi_bit;
            w_ones_next      = w_nrzi_bit ? r_ones + 1'b1 : '0;
          end
        end
        EOP: begin
          if (w_is_j) begin
            w_eop_next       = 1'b1;
            w_rx_active_next = 1'b0;
            w_state_next     = IDLE;
            w_prev_next      = LS_J;
          end else if (w_is_k) begin
            w_rx_active_next = 1'b0;
            w_state_next     = ABORT;
          end
        end
        ABORT: begin
          w_rx_active_next = 1'b0;
          if (w_is_j) begin
            w_state_next = IDLE;
            w_prev_next  = LS_J;
          end
        end
        default: begin
          w_state_next     = IDLE;
          w_prev_next      = LS_J;
          w_rx_active_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_48m or negedge safe_rst_n) begin
    if (!safe_rst_n) begin
      r_phase       <= '0;
      r_se0_cnt     <= '0;
      r_bus_reset   <= 1'b0;
      r_state       <= IDLE;
      r_prev_sample <= LS_J;
      r_zeros       <= '0;
      r_ones        <= '0;
      r_rx_active   <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_bit_data    <= 1'b0;
      r_eop         <= 1'b0;
      r_stuff_err   <= 1'b0;
    end else begin
      r_phase       <= w_phase;
      r_se0_cnt     <= w_se0_cnt_next;
      r_bus_reset   <= w_bus_reset_next;
      r_state       <= w_state_next;
      r_prev_sample <= w_prev_next;
      r_zeros       <= w_zeros_next;
      r_ones        <= w_ones_next;
      r_rx_active   <= w_rx_active_next;
      r_bit_valid   <= w_bit_valid_next;
      r_bit_data    <= w_bit_data_next;
      r_eop         <= w_eop_next;
      r_stuff_err   <= w_stuff_err_next;
    end
  end

`ifdef USB_RX_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk_48m or negedge safe_rst_n) begin
    if (!safe_rst_n) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (r_eop && (r_pkt_count != 16'hFFFF)) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if (r_stuff_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign o_pkt_count = r_pkt_count;
  assign o_err_count = r_err_count;
`else
  assign o_pkt_count = '0;
  assign o_err_count = '0;
`endif

  assign o_rx_active = r_rx_active;
  assign o_bit_valid = r_bit_valid;
  assign o_bit_data  = r_bit_data;
  assign o_eop       = r_eop;
  assign o_stuff_err = r_stuff_err;
  assign o_bus_reset = r_bus_reset;

endmodule
